// File: rtl/cop_wb_queue_pkg.sv
// Shared coprocessor definitions: datapath widths, custom opcodes and write-back entry packing.
// Used by the ISE decoder, the write-back queue and core integration.
package cop_wb_queue_pkg;

    localparam int COP_XLEN  = 32;
    localparam int COP_IDX_W = 5;

    localparam logic [6:0] CUSTOM_0 = 7'b0001011;
    localparam logic [6:0] CUSTOM_1 = 7'b0101011;
    localparam logic [6:0] CUSTOM_2 = 7'b1011011;
    localparam logic [6:0] CUSTOM_3 = 7'b1111011;

    // A queue entry is packed as {idx, data}, index in the upper bits.
    function automatic int entry_width(input int xlen, input int idx_w);
        return xlen + idx_w;
    endfunction

endpackage

// File: rtl/cop_wb_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; also exposes every slot with its valid bit
// so the owner can compare against all pending entries at once.
module cop_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0]                wdata,
    output logic [WIDTH-1:0]                rdata,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH):0]          count,
    output logic [DEPTH-1:0]                slot_valid,
    output logic [DEPTH-1:0][WIDTH-1:0]     slot_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW-1:0]               head_q, head_d;
    logic [PW-1:0]               tail_q, tail_d;
    logic [CW-1:0]               count_q, count_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic                        do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointers wrap naturally at PW bits.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (do_pop) begin
            head_d          = head_q + PW'(1);
            valid_d[head_q] = 1'b0;
        end
        if (do_push) begin
            tail_d          = tail_q + PW'(1);
            valid_d[tail_q] = 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= wdata;
        end
    end

    assign rdata      = mem_q[head_q];
    assign count      = count_q;
    assign slot_valid = valid_q;
    assign slot_data  = mem_q;

endmodule

// File: rtl/cop_wb_queue.sv
// Write-back queue between the coprocessor ISE and the core register-file write port:
// buffers results in order, back-pressures the ISE when full, flags RAW hazards.
module cop_wb_queue
    import cop_wb_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = COP_XLEN,
    parameter int IDX_W = COP_IDX_W,
    parameter int CNT_W = 16
) (
    input  logic                     cop_clk,
    input  logic                     cop_rst,
    input  logic                     cop_wr,
    input  logic [XLEN-1:0]          cop_rd,
    input  logic [IDX_W-1:0]         cop_rd_idx,
    output logic                     cop_rdywr,
    output logic                     wb_req,
    output logic [IDX_W-1:0]         wb_idx,
    output logic [XLEN-1:0]          wb_data,
    input  logic                     wb_gnt,
    input  logic [IDX_W-1:0]         hz_rs1_idx,
    input  logic [IDX_W-1:0]         hz_rs2_idx,
    output logic                     hz_hit,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int EW = entry_width(XLEN, IDX_W);

    logic [EW-1:0]              head_entry;
    logic                       full, empty;
    logic [DEPTH-1:0]           slot_valid;
    logic [DEPTH-1:0][EW-1:0]   slot_data;
    logic                       push_en, pop_en;
    logic [CNT_W-1:0]           stall_q, stall_d;

    // Ready depends only on registered state and reset, never on wb_gnt.
    assign cop_rdywr = !full && !cop_rst;
    assign push_en   = cop_wr && cop_rdywr && (cop_rd_idx != '0);
    assign pop_en    = wb_req && wb_gnt;

    cop_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk        (cop_clk),
        .rst        (cop_rst),
        .push       (push_en),
        .pop        (pop_en),
        .wdata      ({cop_rd_idx, cop_rd}),
        .rdata      (head_entry),
        .full       (full),
        .empty      (empty),
        .count      (occupancy),
        .slot_valid (slot_valid),
        .slot_data  (slot_data)
    );

    assign wb_req  = !empty;
    assign wb_idx  = head_entry[XLEN +: IDX_W];
    assign wb_data = head_entry[XLEN-1:0];

    always_comb begin
        hz_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (slot_data[i][XLEN +: IDX_W] != '0) &&
                ((slot_data[i][XLEN +: IDX_W] == hz_rs1_idx) ||
                 (slot_data[i][XLEN +: IDX_W] == hz_rs2_idx))) begin
                hz_hit = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (cop_wr && !cop_rdywr && !cop_rst && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge cop_clk) begin
        if (cop_rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_cop_wb_queue.sv
// Self-checking bench for cop_wb_queue: directed scenarios plus randomized traffic,
// all compared against a queue-level reference model kept in the bench.
module tb_cop_wb_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 4;
    localparam int OW    = $clog2(DEPTH) + 1;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               copRst;
    logic               copWr;
    logic [XLEN-1:0]    copRd;
    logic [IDX_W-1:0]   copRdIdx;
    logic               wbGnt;
    logic [IDX_W-1:0]   rs1;
    logic [IDX_W-1:0]   rs2;

    logic               cop_rdywr;
    logic               wb_req;
    logic [IDX_W-1:0]   wb_idx;
    logic [XLEN-1:0]    wb_data;
    logic               hz_hit;
    logic [OW-1:0]      occupancy;
    logic [CNT_W-1:0]   stall_cnt;

    int testsRun;
    int testsFailed;

    // Reference model: pending results in order as {idx, data}, plus the stall counter.
    logic [IDX_W+XLEN-1:0] mq[$];
    int                    mStall;

    cop_wb_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .cop_clk    (clk),
        .cop_rst    (copRst),
        .cop_wr     (copWr),
        .cop_rd     (copRd),
        .cop_rd_idx (copRdIdx),
        .cop_rdywr  (cop_rdywr),
        .wb_req     (wb_req),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .wb_gnt     (wbGnt),
        .hz_rs1_idx (rs1),
        .hz_rs2_idx (rs2),
        .hz_hit     (hz_hit),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change in the low phase; outputs are sampled 1ns later, well away from posedge.
    task automatic applyStimulus(input logic wr, input logic [IDX_W-1:0] idx,
                                 input logic [XLEN-1:0] data, input logic gnt,
                                 input logic [IDX_W-1:0] r1, input logic [IDX_W-1:0] r2,
                                 input logic rst);
        copWr    = wr;
        copRdIdx = idx;
        copRd    = data;
        wbGnt    = gnt;
        rs1      = r1;
        rs2      = r2;
        copRst   = rst;
        #1;
    endtask

    // Advance the model by the rules of the queue for the inputs now applied, then clock once.
    task automatic tick();
        bit accept;
        accept = (mq.size() < DEPTH) && !copRst;
        if (copRst) begin
            mq.delete();
            mStall = 0;
        end else begin
            if (copWr && !accept && mStall < STALL_MAX) mStall++;
            if (wbGnt && mq.size() > 0) void'(mq.pop_front());
            if (copWr && accept && copRdIdx != '0) mq.push_back({copRdIdx, copRd});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic modelHazard();
        logic hit;
        logic [IDX_W-1:0] e;
        hit = 1'b0;
        foreach (mq[i]) begin
            e = mq[i][XLEN +: IDX_W];
            if (e != '0 && (e == rs1 || e == rs2)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Reset holds ready low, then leaves an empty, ready queue.
    task automatic test_reset();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
        testsRun++;
        if (cop_rdywr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rdywr_low: got %b expected 0", cop_rdywr); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (cop_rdywr !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_rdywr: got %b expected 1", cop_rdywr); end
        testsRun++;
        if (wb_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wb_req: got %b expected 0", wb_req); end
        testsRun++;
        if (occupancy !== OW'(0)) begin testsFailed++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
        testsRun++;
        if (stall_cnt !== CNT_W'(0)) begin testsFailed++; $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cnt); end
        testsRun++;
        if (hz_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_hz: got %b expected 0", hz_hit); end
    endtask

    // One result flows through with a cycle of latency and is popped immediately.
    task automatic test_single();
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (wb_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_no_bypass: got %b expected 0", wb_req); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (wb_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_req: got %b expected 1", wb_req); end
        testsRun++;
        if (wb_idx !== 5'd5) begin testsFailed++; $display("[TB] FAIL single_idx: got %0d expected 5", wb_idx); end
        testsRun++;
        if (wb_data !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL single_data: got %h expected deadbeef", wb_data); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (occupancy !== OW'(0)) begin testsFailed++; $display("[TB] FAIL single_occ_after_pop: got %0d expected 0", occupancy); end
        tick();
    endtask

    // Fill, stall the third push, then drain in order while the refused push retries.
    task automatic test_full_drain();
        applyStimulus(1'b1, 5'd1, 32'hA0000001, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd2, 32'hA0000002, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd3, 32'hA0000003, 1'b0, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (cop_rdywr !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_rdywr: got %b expected 0", cop_rdywr); end
        testsRun++;
        if (occupancy !== OW'(2)) begin testsFailed++; $display("[TB] FAIL full_occ: got %0d expected 2", occupancy); end
        tick();
        applyStimulus(1'b1, 5'd3, 32'hA0000003, 1'b1, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (stall_cnt !== CNT_W'(1)) begin testsFailed++; $display("[TB] FAIL full_stall_cnt: got %0d expected 1", stall_cnt); end
        testsRun++;
        if (cop_rdywr !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_pop_push_refused: got %b expected 0", cop_rdywr); end
        testsRun++;
        if (wb_idx !== 5'd1) begin testsFailed++; $display("[TB] FAIL drain_first: got %0d expected 1", wb_idx); end
        tick();
        applyStimulus(1'b1, 5'd3, 32'hA0000003, 1'b0, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (cop_rdywr !== 1'b1) begin testsFailed++; $display("[TB] FAIL retry_accept: got %b expected 1", cop_rdywr); end
        testsRun++;
        if (wb_idx !== 5'd2) begin testsFailed++; $display("[TB] FAIL drain_second: got %0d expected 2", wb_idx); end
        testsRun++;
        if (stall_cnt !== CNT_W'(2)) begin testsFailed++; $display("[TB] FAIL stall_second: got %0d expected 2", stall_cnt); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (occupancy !== OW'(2)) begin testsFailed++; $display("[TB] FAIL refill_occ: got %0d expected 2", occupancy); end
        testsRun++;
        if (wb_idx !== 5'd2 || wb_data !== 32'hA0000002) begin testsFailed++; $display("[TB] FAIL hold_head: got %0d/%h expected 2/a0000002", wb_idx, wb_data); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (wb_idx !== 5'd3 || wb_data !== 32'hA0000003) begin testsFailed++; $display("[TB] FAIL drain_third: got %0d/%h expected 3/a0000003", wb_idx, wb_data); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (occupancy !== OW'(0) || wb_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_empty: got occ %0d req %b expected 0 0", occupancy, wb_req); end
        tick();
    endtask

    // Writes to x0 are accepted and dropped.
    task automatic test_x0_discard();
        applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (cop_rdywr !== 1'b1) begin testsFailed++; $display("[TB] FAIL x0_rdywr: got %b expected 1", cop_rdywr); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (occupancy !== OW'(0) || wb_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL x0_dropped: got occ %0d req %b expected 0 0", occupancy, wb_req); end
        tick();
    endtask

    // Hazard only from registered entries, never from index 0, cleared once popped.
    task automatic test_hazard();
        applyStimulus(1'b1, 5'd7, 32'h77777777, 1'b0, 5'd7, 5'd7, 1'b0);
        testsRun++;
        if (hz_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL hz_incoming: got %b expected 0", hz_hit); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0, 1'b0);
        testsRun++;
        if (hz_hit !== 1'b1) begin testsFailed++; $display("[TB] FAIL hz_rs1: got %b expected 1", hz_hit); end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (hz_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL hz_zero: got %b expected 0", hz_hit); end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd7, 1'b0);
        testsRun++;
        if (hz_hit !== 1'b1) begin testsFailed++; $display("[TB] FAIL hz_rs2: got %b expected 1", hz_hit); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7, 1'b0);
        testsRun++;
        if (hz_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL hz_after_pop: got %b expected 0", hz_hit); end
        tick();
    endtask

    // Reset with entries pending drops them and clears the stall counter.
    task automatic test_reset_mid();
        applyStimulus(1'b1, 5'd4, 32'hB0000004, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd6, 32'hB0000006, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd9, 32'hB0000009, 1'b1, 5'd0, 5'd0, 1'b1);
        testsRun++;
        if (cop_rdywr !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_rdywr: got %b expected 0", cop_rdywr); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd6, 1'b0);
        testsRun++;
        if (wb_req !== 1'b0 || occupancy !== OW'(0)) begin testsFailed++; $display("[TB] FAIL midrst_dropped: got req %b occ %0d expected 0 0", wb_req, occupancy); end
        testsRun++;
        if (stall_cnt !== CNT_W'(0) || cop_rdywr !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_state: got stall %0d rdy %b expected 0 1", stall_cnt, cop_rdywr); end
        testsRun++;
        if (hz_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_hz: got %b expected 0", hz_hit); end
        tick();
    endtask

    // Stall counter holds at all-ones under sustained back-pressure.
    task automatic test_stall_saturate();
        for (int i = 0; i < DEPTH + 20; i++) begin
            applyStimulus(1'b1, 5'd10, 32'hC0000000 + i, 1'b0, 5'd0, 5'd0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        testsRun++;
        if (stall_cnt !== CNT_W'(STALL_MAX)) begin testsFailed++; $display("[TB] FAIL stall_saturate: got %0d expected %0d", stall_cnt, STALL_MAX); end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
        tick();
    endtask

    // Random traffic: every output checked against the model each cycle.
    task automatic test_random();
        logic [IDX_W-1:0] headIdx;
        logic [XLEN-1:0]  headData;
        for (int c = 0; c < 500; c++) begin
            applyStimulus(1'($urandom_range(0, 9) < 6), IDX_W'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 9) < 4), IDX_W'($urandom_range(0, 7)),
                          IDX_W'($urandom_range(0, 7)), 1'($urandom_range(0, 59) == 0));
            testsRun++;
            if (cop_rdywr !== ((mq.size() < DEPTH) && !copRst)) begin testsFailed++; $display("[TB] FAIL rand_rdywr cycle %0d: got %b expected %b", c, cop_rdywr, (mq.size() < DEPTH) && !copRst); end
            testsRun++;
            if (occupancy !== OW'(mq.size())) begin testsFailed++; $display("[TB] FAIL rand_occ cycle %0d: got %0d expected %0d", c, occupancy, mq.size()); end
            testsRun++;
            if (wb_req !== (mq.size() > 0)) begin testsFailed++; $display("[TB] FAIL rand_req cycle %0d: got %b expected %b", c, wb_req, mq.size() > 0); end
            testsRun++;
            if (stall_cnt !== CNT_W'(mStall)) begin testsFailed++; $display("[TB] FAIL rand_stall cycle %0d: got %0d expected %0d", c, stall_cnt, mStall); end
            testsRun++;
            if (hz_hit !== modelHazard()) begin testsFailed++; $display("[TB] FAIL rand_hz cycle %0d: got %b expected %b", c, hz_hit, modelHazard()); end
            if (mq.size() > 0) begin
                headIdx  = mq[0][XLEN +: IDX_W];
                headData = mq[0][XLEN-1:0];
                testsRun++;
                if (wb_idx !== headIdx || wb_data !== headData) begin testsFailed++; $display("[TB] FAIL rand_head cycle %0d: got %0d/%h expected %0d/%h", c, wb_idx, wb_data, headIdx, headData); end
            end
            tick();
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        mStall      = 0;
        copRst      = 1'b1;
        copWr       = 1'b0;
        copRd       = '0;
        copRdIdx    = '0;
        wbGnt       = 1'b0;
        rs1         = '0;
        rs2         = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_full_drain();
        test_x0_discard();
        test_hazard();
        test_reset_mid();
        test_stall_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
